mem_access_ctrl: RTL and testbench
==================================

// Module: mem_access_ctrl
// PURPOSE
//   Memory cycle sequencer downstream of the 16-bit address register. It takes the
//   register's current value as the address and runs one SRAM/ROM read or write
//   cycle with registered, glitch-free strobes and programmable wait states.
//   Read data is captured into a data register (MDR) that can be driven onto the
//   bus. An optional ADDR_INC pulse feeds the address register's INC input, so
//   sequential accesses step through memory.
// PARAMETERS
//   WAIT_STATES  2   extra ACCESS cycles beyond the first; legal 0..15
// PORTS
//   CLK            in   1   clock; all state changes on rising edge
//   RST_bar        in   1   reset, synchronous, active-low
//   REQ            in   1   start a memory cycle; sampled only in IDLE
//   WE             in   1   1 = write, 0 = read; captured with REQ
//   AUTO_INC       in   1   1 = pulse ADDR_INC at end of cycle; captured with REQ
//   ADDR_in        in   16  address from address register value
//   DATA_in        in   8   write data from bus; captured with REQ
//   ASSERT_bar     in   1   0 = drive MDR onto BUS_out
//   BUS_out        out  8   MDR when ASSERT_bar=0, else 8'bz
//   MEM_ADDR       out  16  latched address to memory
//   MEM_DATA_out   out  8   latched write data to memory
//   MEM_DATA_in    in   8   read data from memory
//   MEM_CE_bar     out  1   chip enable, active-low
//   MEM_OE_bar     out  1   output enable, active-low (reads)
//   MEM_WE_bar     out  1   write enable, active-low (writes)
//   BUSY           out  1   1 whenever state != IDLE
//   DONE           out  1   one-cycle pulse in HOLD
//   ADDR_INC       out  1   one-cycle pulse in HOLD if captured AUTO_INC=1
//   display_value  out  8   MDR contents, for LEDs
// BEHAVIOUR
//   Reset (RST_bar=0 at edge, any state): state=IDLE, MDR=0, MEM_ADDR=0,
//     MEM_DATA_out=0, count=0. Next cycle: all *_bar strobes=1, BUSY=DONE=ADDR_INC=0.
//     Aborts a cycle in progress; MDR is cleared, not partially updated.
//   Outputs: Moore only, decoded from registered state. No input-to-strobe
//     combinational path; BUS_out tri-state gate is the only combinational output.
//   FSM states: IDLE -> SETUP -> ACCESS (xW+1) -> HOLD -> IDLE.
//   IDLE: strobes high. If REQ=1, capture ADDR_in, WE, DATA_in, AUTO_INC; go SETUP.
//   SETUP (1 cycle): CE_bar=0, OE_bar=WE_bar=1; count<=WAIT_STATES; go ACCESS.
//   ACCESS: CE_bar=0. Read: OE_bar=0. Write: WE_bar=0. Decrement count each edge.
//     At the edge with count==0: go HOLD. A read also loads MDR<=MEM_DATA_in at
//     this edge. ACCESS lasts exactly WAIT_STATES+1 cycles.
//   HOLD (1 cycle): CE_bar=0, OE_bar=WE_bar=1 (address/data held for hold time);
//     DONE=1; ADDR_INC=captured AUTO_INC; always go IDLE.
//   Latency: with REQ sampled at edge 0, HOLD/DONE is visible after edge W+2.
//     Next REQ can be sampled at edge W+4; minimum period is W+4 cycles. HOLD never
//     goes directly to SETUP: the address register increments at the edge leaving
//     HOLD, and ADDR_in must be re-sampled after that edge.
//   REQ while BUSY: ignored, not queued. Changes to ADDR_in/WE/DATA_in/AUTO_INC
//     after the capture edge have no effect on the current cycle.
//   Write cycles leave MDR unchanged. MEM_DATA_out keeps its last captured value.
//   WAIT_STATES=0: ACCESS lasts 1 cycle; the count must not underflow or wrap.
// TESTING
//   Read, W=2: ADDR_in=16'h1234, REQ 1 cycle, MEM_DATA_in=8'hA5 -> MEM_ADDR=1234;
//     OE_bar low 3 cycles; DONE after edge 4; MDR=A5; BUS_out=A5 when ASSERT_bar=0.
//   Write, W=0: DATA_in=8'h3C, WE=1 -> WE_bar low exactly 1 cycle; OE_bar stays 1;
//     MEM_DATA_out=3C; MDR unchanged; DONE after edge 2.
//   AUTO_INC loop with address register model at FFFE: two reads -> ADDR_INC
//     pulses twice; second MEM_ADDR=FFFF; register wraps to 0000.
//   REQ held high continuously, W=1 -> new cycle every 5 cycles; REQ while BUSY
//     does not stretch or restart the current cycle.
//   RST_bar=0 mid-ACCESS -> next cycle all strobes=1, BUSY=0, MDR=0, no DONE pulse.
//   ASSERT_bar=1 -> BUS_out=8'bz in every state.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// Memory cycle sequencer: runs one SRAM/ROM read or write cycle with registered,
// Moore-decoded strobes, programmable wait states and a captured read-data register.
module mem_access_ctrl #(
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic        CLK,
  input  logic        RST_bar,
  input  logic        REQ,
  input  logic        WE,
  input  logic        AUTO_INC,
  input  logic [15:0] ADDR_in,
  input  logic [7:0]  DATA_in,
  input  logic        ASSERT_bar,
  output logic [7:0]  BUS_out,
  output logic [15:0] MEM_ADDR,
  output logic [7:0]  MEM_DATA_out,
  input  logic [7:0]  MEM_DATA_in,
  output logic        MEM_CE_bar,
  output logic        MEM_OE_bar,
  output logic        MEM_WE_bar,
  output logic        BUSY,
  output logic        DONE,
  output logic        ADDR_INC,
  output logic [7:0]  display_value
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    HOLD   = 2'd3
  } state_t;

  state_t      state, state_next;
  logic [7:0]  mdr;
  logic [3:0]  count;
  logic        we_r;
  logic        auto_inc_r;

  always_ff @(posedge CLK) begin
    if (!RST_bar) begin
      state        <= IDLE;
      mdr          <= '0;
      MEM_ADDR     <= '0;
      MEM_DATA_out <= '0;
      count        <= '0;
      we_r         <= 1'b0;
      auto_inc_r   <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (REQ) begin
            MEM_ADDR     <= ADDR_in;
            MEM_DATA_out <= DATA_in;
            we_r         <= WE;
            auto_inc_r   <= AUTO_INC;
          end
        end
        SETUP: count <= 4'(WAIT_STATES);
        ACCESS: begin
          // Count stops at zero so WAIT_STATES=0 never wraps
          if (count == '0) begin
            if (!we_r) mdr <= MEM_DATA_in;
          end else begin
            count <= count - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (REQ) state_next = SETUP;
      SETUP:   state_next = ACCESS;
      ACCESS:  if (count == '0) state_next = HOLD;
      HOLD:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    MEM_CE_bar = 1'b1;
    MEM_OE_bar = 1'b1;
    MEM_WE_bar = 1'b1;
    BUSY       = 1'b0;
    DONE       = 1'b0;
    ADDR_INC   = 1'b0;
    case (state)
      SETUP: begin
        MEM_CE_bar = 1'b0;
        BUSY       = 1'b1;
      end
      ACCESS: begin
        MEM_CE_bar = 1'b0;
        MEM_OE_bar = we_r;
        MEM_WE_bar = !we_r;
        BUSY       = 1'b1;
      end
      HOLD: begin
        MEM_CE_bar = 1'b0;
        BUSY       = 1'b1;
        DONE       = 1'b1;
        ADDR_INC   = auto_inc_r;
      end
      default: ;
    endcase
  end

  assign BUS_out       = ASSERT_bar ? 'z : mdr;
  assign display_value = mdr;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: three instances (W=2, W=0, W=1) share inputs
// except REQ; expected values are hand-computed from the cycle timing.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, we, auto_inc, assert_bar;
  logic [15:0] addr;
  logic [7:0]  data_in, mem_data_in;
  logic        req_a, req_b, req_c;

  logic [7:0]  bus_a, mdo_a, disp_a, bus_b, mdo_b, disp_b, bus_c, mdo_c, disp_c;
  logic [15:0] maddr_a, maddr_b, maddr_c;
  logic        ce_a, oe_a, wen_a, busy_a, done_a, inc_a;
  logic        ce_b, oe_b, wen_b, busy_b, done_b, inc_b;
  logic        ce_c, oe_c, wen_c, busy_c, done_c, inc_c;

  int checks = 0;
  int errors = 0;
  logic [15:0] addr_reg;
  int inc_pulses;

  always #5 clk = ~clk;

  mem_access_ctrl #(.WAIT_STATES(2)) dut_a (
    .CLK(clk), .RST_bar(rst_n), .REQ(req_a), .WE(we), .AUTO_INC(auto_inc),
    .ADDR_in(addr), .DATA_in(data_in), .ASSERT_bar(assert_bar), .BUS_out(bus_a),
    .MEM_ADDR(maddr_a), .MEM_DATA_out(mdo_a), .MEM_DATA_in(mem_data_in),
    .MEM_CE_bar(ce_a), .MEM_OE_bar(oe_a), .MEM_WE_bar(wen_a), .BUSY(busy_a),
    .DONE(done_a), .ADDR_INC(inc_a), .display_value(disp_a));

  mem_access_ctrl #(.WAIT_STATES(0)) dut_b (
    .CLK(clk), .RST_bar(rst_n), .REQ(req_b), .WE(we), .AUTO_INC(auto_inc),
    .ADDR_in(addr), .DATA_in(data_in), .ASSERT_bar(assert_bar), .BUS_out(bus_b),
    .MEM_ADDR(maddr_b), .MEM_DATA_out(mdo_b), .MEM_DATA_in(mem_data_in),
    .MEM_CE_bar(ce_b), .MEM_OE_bar(oe_b), .MEM_WE_bar(wen_b), .BUSY(busy_b),
    .DONE(done_b), .ADDR_INC(inc_b), .display_value(disp_b));

  mem_access_ctrl #(.WAIT_STATES(1)) dut_c (
    .CLK(clk), .RST_bar(rst_n), .REQ(req_c), .WE(we), .AUTO_INC(auto_inc),
    .ADDR_in(addr), .DATA_in(data_in), .ASSERT_bar(assert_bar), .BUS_out(bus_c),
    .MEM_ADDR(maddr_c), .MEM_DATA_out(mdo_c), .MEM_DATA_in(mem_data_in),
    .MEM_CE_bar(ce_c), .MEM_OE_bar(oe_c), .MEM_WE_bar(wen_c), .BUSY(busy_c),
    .DONE(done_c), .ADDR_INC(inc_c), .display_value(disp_c));

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One rising edge, then settle 1ns before driving or sampling
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_strobes(input string tag, input logic ce, input logic oe, input logic wen);
    check({tag, ".ce"}, {15'd0, ce_a}, {15'd0, ce});
    check({tag, ".oe"}, {15'd0, oe_a}, {15'd0, oe});
    check({tag, ".we"}, {15'd0, wen_a}, {15'd0, wen});
  endtask

  initial begin
    logic [15:0] zz;
    zz = {8'h00, 8'hzz};
    rst_n = 1'b0; we = 1'b0; auto_inc = 1'b0; assert_bar = 1'b1;
    addr = 16'h0000; data_in = 8'h00; mem_data_in = 8'h00;
    req_a = 1'b0; req_b = 1'b0; req_c = 1'b0;
    tick(); tick();
    rst_n = 1'b1;

    // Reset state
    check_strobes("rst", 1'b1, 1'b1, 1'b1);
    check("rst.busy", {15'd0, busy_a}, 16'd0);
    check("rst.done", {15'd0, done_a}, 16'd0);
    check("rst.inc", {15'd0, inc_a}, 16'd0);
    check("rst.mdr", {8'd0, disp_a}, 16'd0);
    check("rst.maddr", maddr_a, 16'd0);
    check("rst.mdo", {8'd0, mdo_a}, 16'd0);
    check("rst.bus_z", {8'h00, bus_a}, zz);

    // Read, W=2
    addr = 16'h1234; we = 1'b0; mem_data_in = 8'hA5; req_a = 1'b1;
    tick();                                   // edge 0 -> SETUP
    req_a = 1'b0; addr = 16'h0000;
    check_strobes("rd.setup", 1'b0, 1'b1, 1'b1);
    check("rd.maddr", maddr_a, 16'h1234);
    check("rd.busy", {15'd0, busy_a}, 16'd1);
    check("rd.setup_z", {8'h00, bus_a}, zz);
    for (int i = 1; i <= 3; i++) begin        // edges 1..3 -> ACCESS
      tick();
      check_strobes($sformatf("rd.acc%0d", i), 1'b0, 1'b0, 1'b1);
      check("rd.acc_done", {15'd0, done_a}, 16'd0);
      check("rd.acc_z", {8'h00, bus_a}, zz);
    end
    tick();                                   // edge 4 -> HOLD
    check_strobes("rd.hold", 1'b0, 1'b1, 1'b1);
    check("rd.done", {15'd0, done_a}, 16'd1);
    check("rd.inc", {15'd0, inc_a}, 16'd0);
    check("rd.mdr", {8'd0, disp_a}, 16'h00A5);
    check("rd.hold_z", {8'h00, bus_a}, zz);
    tick();                                   // edge 5 -> IDLE
    check_strobes("rd.idle", 1'b1, 1'b1, 1'b1);
    check("rd.idle_busy", {15'd0, busy_a}, 16'd0);
    check("rd.idle_done", {15'd0, done_a}, 16'd0);
    assert_bar = 1'b0; #1;
    check("rd.bus", {8'd0, bus_a}, 16'h00A5);
    assert_bar = 1'b1; #1;
    check("rd.bus_z", {8'h00, bus_a}, zz);

    // W=0: read 5A first so the write can prove MDR is left alone
    we = 1'b0; mem_data_in = 8'h5A; req_b = 1'b1;
    tick(); req_b = 1'b0;
    tick(); tick();
    check("w0rd.done", {15'd0, done_b}, 16'd1);
    check("w0rd.mdr", {8'd0, disp_b}, 16'h005A);
    tick();
    data_in = 8'h3C; we = 1'b1; mem_data_in = 8'h77; req_b = 1'b1;
    tick();                                   // edge 0 -> SETUP
    req_b = 1'b0; data_in = 8'h00;
    check("wr.setup_we", {15'd0, wen_b}, 16'd1);
    check("wr.setup_oe", {15'd0, oe_b}, 16'd1);
    tick();                                   // edge 1 -> ACCESS (single cycle)
    check("wr.acc_we", {15'd0, wen_b}, 16'd0);
    check("wr.acc_oe", {15'd0, oe_b}, 16'd1);
    check("wr.acc_ce", {15'd0, ce_b}, 16'd0);
    tick();                                   // edge 2 -> HOLD
    check("wr.hold_we", {15'd0, wen_b}, 16'd1);
    check("wr.hold_oe", {15'd0, oe_b}, 16'd1);
    check("wr.done", {15'd0, done_b}, 16'd1);
    check("wr.mdo", {8'd0, mdo_b}, 16'h003C);
    check("wr.mdr", {8'd0, disp_b}, 16'h005A);
    tick();
    check("wr.idle_busy", {15'd0, busy_b}, 16'd0);
    check("wr.idle_mdo", {8'd0, mdo_b}, 16'h003C);
    we = 1'b0;

    // AUTO_INC loop with address register model starting at FFFE
    addr_reg = 16'hFFFE; inc_pulses = 0; auto_inc = 1'b1; mem_data_in = 8'hE1;
    for (int n = 0; n < 2; n++) begin
      addr = addr_reg; req_a = 1'b1;
      tick(); req_a = 1'b0;
      check($sformatf("ai%0d.maddr", n), maddr_a, (n == 0) ? 16'hFFFE : 16'hFFFF);
      check($sformatf("ai%0d.inc_early", n), {15'd0, inc_a}, 16'd0);
      tick(); tick(); tick(); tick();         // edges 1..4, now HOLD
      check($sformatf("ai%0d.done", n), {15'd0, done_a}, 16'd1);
      check($sformatf("ai%0d.inc", n), {15'd0, inc_a}, 16'd1);
      if (inc_a) begin
        inc_pulses++;
        addr_reg = addr_reg + 16'd1;
      end
      tick();
      check($sformatf("ai%0d.inc_off", n), {15'd0, inc_a}, 16'd0);
    end
    check("ai.pulses", 16'(inc_pulses), 16'd2);
    check("ai.wrap", addr_reg, 16'h0000);
    check("ai.mdr", {8'd0, disp_a}, 16'h00E1);
    auto_inc = 1'b0;

    // REQ held high, W=1: one cycle every 5 clocks
    req_c = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick();
      check($sformatf("hold.done%0d", i), {15'd0, done_c}, (i % 5 == 3) ? 16'd1 : 16'd0);
      check($sformatf("hold.busy%0d", i), {15'd0, busy_c}, (i % 5 == 4) ? 16'd0 : 16'd1);
    end
    req_c = 1'b0;
    tick(); tick(); tick(); tick(); tick();
    check("hold.idle", {15'd0, busy_c}, 16'd0);

    // Reset in the middle of ACCESS
    addr = 16'hBEEF; mem_data_in = 8'h99; req_a = 1'b1;
    tick(); req_a = 1'b0;
    tick(); tick();
    check("ab.in_access", {15'd0, oe_a}, 16'd0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_strobes("ab", 1'b1, 1'b1, 1'b1);
    check("ab.busy", {15'd0, busy_a}, 16'd0);
    check("ab.mdr", {8'd0, disp_a}, 16'd0);
    check("ab.maddr", maddr_a, 16'd0);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("ab.nodone%0d", i), {15'd0, done_a}, 16'd0);
      tick();
    end
    check("ab.end_z", {8'h00, bus_a}, zz);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
